data_ram: RTL and testbench
===========================

# data_ram

Single-port-write, single-port-read data memory for the single-cycle CPU. The read address and write address are independent, and reads are combinational so that loaded data reaches the ALUs, the register write-data mux and the word matcher within the same cycle. Writes commit on the rising clock edge. The block sits between the control/mux fabric and the register file.

## Interface
Parameters:
- DW, 16 — data word width.
- AW, 16 — address bus width.
- DEPTH, 256 — number of words; valid addresses are 0..DEPTH-1.

Ports:
- CLK, input, 1 — sole clock; all state changes occur on its rising edge.
- Init, input, 1 — reset, synchronous and active-high.
- DataAddress, input, AW — read address.
- MemWriteIndex, input, AW — write address.
- ReadMem, input, 1 — read enable.
- WriteMem, input, 1 — write enable.
- DataIn, input, DW — write data.
- DataOut, output, DW — read data (combinational).

## Operation
- Storage is an array of DEPTH words, each DW bits wide.
- Read path:
  - DataOut = mem[DataAddress] when ReadMem=1, Init=0 and DataAddress < DEPTH.
  - Otherwise DataOut = 0.
- Write path:
  - mem[MemWriteIndex] <= DataIn at the rising CLK edge when WriteMem=1, Init=0 and MemWriteIndex < DEPTH.
- Out-of-range handling:
  - Reads at an address >= DEPTH return 0.
  - Writes at an address >= DEPTH are silently dropped; no aliasing, the upper address bits are not truncated.
- Reset: at a rising edge with Init=1, every word is cleared to 0 and any concurrent write is discarded (Init has priority).
- A read and a write in the same cycle are independent, whether the addresses match or not. Same-address behaviour is set by the macro in Configuration.
- ReadMem and WriteMem may both be 1 in the same cycle; both take effect.

## Timing
- Read latency is 0 cycles: DataOut follows DataAddress, ReadMem and Init combinationally.
- Write latency is 1 edge: the new value becomes visible on DataOut immediately after the committing edge.
- Reset value:
  - DataOut = 0 while Init=1.
  - After the first edge with Init=1, all words read 0.
- Reset asserted mid-operation: the cycle's write is lost and all contents are cleared at that edge.
- No handshake. Enables are sampled at every edge.

## Configuration
- Macro DATA_RAM_BYPASS_EN.
- Defined: when WriteMem=1, ReadMem=1, Init=0 and DataAddress == MemWriteIndex (and in range), DataOut = DataIn, i.e. write-through forwarding of the pending write.
- Undefined: DataOut shows the old stored word until the edge commits the write.

## Structure
- Package data_ram_pkg holds:
  - the default constants DW, AW and DEPTH;
  - the function in_range(addr), which returns addr < DEPTH.
- One sub-module is natural: data_ram_array, the bare storage with clear, write port and async read. The top level adds range checks, the read gating and the bypass mux.

## Test plan
- Reset clear: write 16'hBEEF to address 5, then pulse Init for one edge, then read address 5 with ReadMem=1 -> DataOut = 0.
- Write then read: write 16'h1234 at address 10; on the next cycle set DataAddress=10, ReadMem=1 -> DataOut = 16'h1234. With ReadMem=0 -> DataOut = 0.
- Same-address read and write of 16'hAAAA over old value 16'h5555:
  - Before the edge, DataOut = 16'h5555 without the macro and 16'hAAAA with DATA_RAM_BYPASS_EN.
  - After the edge, DataOut = 16'hAAAA in both builds.
- Independent ports: write 16'h0007 at address 3 while reading address 4 (holding 16'h0009) -> DataOut = 16'h0009; address 3 then reads 16'h0007.
- Out of range:
  - Write 16'hFFFF at address 300 -> no stored word changes; address 300 & 255 = 44 still reads its prior value.
  - Read at address 300 -> DataOut = 0.
- Init priority: Init=1 and WriteMem=1 at address 7 with 16'h00FF on the same edge -> address 7 reads 0 afterwards.

Source files
------------

// File: rtl/data_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_pkg
// Purpose  : Default geometry and address-range helper for the data memory.
// Revision : 1.0 - initial release
// ============================================================================
package data_ram_pkg;

    localparam int DW    = 16;   // data word width
    localparam int AW    = 16;   // address bus width
    localparam int DEPTH = 256;  // number of stored words

    // True when addr names a real word; the full address is compared so that
    // upper bits never alias onto a lower word.
    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned depth = DEPTH);
        return (addr < depth);
    endfunction

endpackage : data_ram_pkg
`default_nettype wire

// File: rtl/data_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_if
// Purpose  : Read/write bus of the data memory (master = CPU fabric,
//            slave = data_ram).
// Revision : 1.0 - initial release
// ============================================================================
interface data_ram_if
    import data_ram_pkg::*;
#(
    parameter int DW = data_ram_pkg::DW,
    parameter int AW = data_ram_pkg::AW
) ();

    logic [AW-1:0] DataAddress;
    logic [AW-1:0] MemWriteIndex;
    logic          ReadMem;
    logic          WriteMem;
    logic [DW-1:0] DataIn;
    logic [DW-1:0] DataOut;

    modport master (
        output DataAddress,
        output MemWriteIndex,
        output ReadMem,
        output WriteMem,
        output DataIn,
        input  DataOut
    );

    modport slave (
        input  DataAddress,
        input  MemWriteIndex,
        input  ReadMem,
        input  WriteMem,
        input  DataIn,
        output DataOut
    );

endinterface : data_ram_if
`default_nettype wire

// File: rtl/data_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_array
// Purpose  : Bare word storage: synchronous clear, one write port and one
//            asynchronous read port. Addresses are already range-checked.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int DW    = data_ram_pkg::DW,
    parameter int DEPTH = data_ram_pkg::DEPTH,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic          clk,
    input  wire logic          clr,
    input  wire logic          we,
    input  wire logic [IW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [IW-1:0] raddr,
    output logic      [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Clear wipes every word and wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Asynchronous read so loaded data is usable in the same cycle.
    always_comb begin
        rdata = r_mem[raddr];
    end

endmodule : data_ram_array
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram
// Purpose  : Data memory for the single-cycle CPU. Independent read and
//            write addresses, combinational read, write on rising CLK.
//            Out-of-range reads return 0, out-of-range writes are dropped.
//            Optional macro DATA_RAM_BYPASS_EN forwards a same-address
//            pending write straight to DataOut.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram #(
    parameter int DW    = data_ram_pkg::DW,
    parameter int AW    = data_ram_pkg::AW,
    parameter int DEPTH = data_ram_pkg::DEPTH
) (
    input  wire logic   CLK,
    input  wire logic   Init,
    data_ram_if.slave   bus
);

    import data_ram_pkg::*;

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [DW-1:0] w_rd_data;
    logic [DW-1:0] w_rd_sel;

    // Range checks use the full address width so that no aliasing occurs.
    always_comb begin
        w_rd_ok = in_range(32'(bus.DataAddress), DEPTH);
        w_wr_ok = in_range(32'(bus.MemWriteIndex), DEPTH);
        w_wr_en = bus.WriteMem & ~Init & w_wr_ok;
        w_rd_en = bus.ReadMem  & ~Init & w_rd_ok;
    end

    data_ram_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (CLK),
        .clr   (Init),
        .we    (w_wr_en),
        .waddr (bus.MemWriteIndex[IW-1:0]),
        .wdata (bus.DataIn),
        .raddr (bus.DataAddress[IW-1:0]),
        .rdata (w_rd_data)
    );

`ifdef DATA_RAM_BYPASS_EN
    // Write-through: a pending write to the address being read is forwarded.
    always_comb begin
        w_rd_sel = w_rd_data;
        if (w_wr_en && (bus.DataAddress == bus.MemWriteIndex)) begin
            w_rd_sel = bus.DataIn;
        end
    end
`else
    // No forwarding: the old word is visible until the write commits.
    always_comb begin
        w_rd_sel = w_rd_data;
    end
`endif

    // Output is gated to zero when not reading, in reset, or out of range.
    always_comb begin
        bus.DataOut = w_rd_en ? w_rd_sel : '0;
    end

endmodule : data_ram
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram
// Purpose  : Directed self-checking bench for data_ram.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram;

    logic CLK;
    logic Init;
    int   n_checks;
    int   n_fail;

    data_ram_if #(.DW(16), .AW(16)) bus ();

    data_ram #(
        .DW    (16),
        .AW    (16),
        .DEPTH (256)
    ) dut (
        .CLK  (CLK),
        .Init (Init),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        bus.MemWriteIndex = addr;
        bus.DataIn        = data;
        bus.WriteMem      = 1'b1;
        tick();
        bus.WriteMem      = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] addr,
                            input logic [15:0] exp);
        bus.DataAddress = addr;
        bus.ReadMem     = 1'b1;
        #1;
        check(tag, bus.DataOut, exp);
    endtask

    logic [15:0] exp_same;

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        Init              = 1'b1;
        bus.DataAddress   = '0;
        bus.MemWriteIndex = '0;
        bus.ReadMem       = 1'b1;
        bus.WriteMem      = 1'b0;
        bus.DataIn        = '0;
        #1;
        check("reset_out_while_init", bus.DataOut, 16'h0000);
        tick();
        Init = 1'b0;
        rd_check("reset_word0", 16'd0, 16'h0000);

        // Reset clear
        wr(16'd5, 16'hBEEF);
        rd_check("pre_clear_5", 16'd5, 16'hBEEF);
        Init = 1'b1;
        tick();
        Init = 1'b0;
        rd_check("post_clear_5", 16'd5, 16'h0000);

        // Write then read, read enable gating
        wr(16'd10, 16'h1234);
        rd_check("read_10", 16'd10, 16'h1234);
        bus.ReadMem = 1'b0;
        #1;
        check("readmem_off", bus.DataOut, 16'h0000);

        // Same-address read and write
        wr(16'd20, 16'h5555);
        bus.MemWriteIndex = 16'd20;
        bus.DataIn        = 16'hAAAA;
        bus.WriteMem      = 1'b1;
`ifdef DATA_RAM_BYPASS_EN
        exp_same = 16'hAAAA;
`else
        exp_same = 16'h5555;
`endif
        rd_check("same_addr_before", 16'd20, exp_same);
        tick();
        bus.WriteMem = 1'b0;
        #1;
        check("same_addr_after", bus.DataOut, 16'hAAAA);

        // Independent ports
        wr(16'd4, 16'h0009);
        bus.MemWriteIndex = 16'd3;
        bus.DataIn        = 16'h0007;
        bus.WriteMem      = 1'b1;
        rd_check("indep_read_4", 16'd4, 16'h0009);
        tick();
        bus.WriteMem = 1'b0;
        rd_check("indep_read_3", 16'd3, 16'h0007);
        rd_check("indep_read_4_again", 16'd4, 16'h0009);

        // Out of range: no aliasing onto 300 & 255 = 44
        wr(16'd44, 16'h1111);
        wr(16'd300, 16'hFFFF);
        rd_check("oor_no_alias_44", 16'd44, 16'h1111);
        rd_check("oor_read_300", 16'd300, 16'h0000);

        // Boundary: last valid word and first invalid one
        wr(16'd255, 16'h0A0A);
        rd_check("last_word_255", 16'd255, 16'h0A0A);
        wr(16'd256, 16'hBBBB);
        rd_check("oor_no_alias_0", 16'd0, 16'h0000);
        rd_check("oor_read_256", 16'd256, 16'h0000);
        bus.MemWriteIndex = 16'd256;
        bus.DataIn        = 16'hCCCC;
        bus.WriteMem      = 1'b1;
        rd_check("oor_no_bypass_256", 16'd256, 16'h0000);
        tick();
        bus.WriteMem = 1'b0;

        // Init priority over a concurrent write; output gated during Init
        wr(16'd7, 16'h1111);
        Init              = 1'b1;
        bus.MemWriteIndex = 16'd7;
        bus.DataIn        = 16'h00FF;
        bus.WriteMem      = 1'b1;
        rd_check("init_gates_read_10", 16'd10, 16'h0000);
        tick();
        Init         = 1'b0;
        bus.WriteMem = 1'b0;
        rd_check("init_prio_7", 16'd7, 16'h0000);
        rd_check("init_clears_10", 16'd10, 16'h0000);
        rd_check("init_clears_255", 16'd255, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_ram
`default_nettype wire
